// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit.
// Optional bne support is selected in mc_control_unit with MC_CTRL_BNE_EN.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_R_WB,
        S_I_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP
    } state_t;

    // Tells the ALU-op decoder which field drives the operation this cycle.
    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_RTYPE,
        CLS_IMM,
        CLS_BRANCH
    } alu_class_t;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB_AB = 4'b0001;
    localparam logic [3:0] ALU_SUB_BA = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_AND    = 4'b0100;
    localparam logic [3:0] ALU_SLT    = 4'b0101;
    localparam logic [3:0] ALU_NOR    = 4'b0110;
    localparam logic [3:0] ALU_SLL    = 4'b0111;
    localparam logic [3:0] ALU_SRL    = 4'b1000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [1:0] SRCB_BUSB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc_a;
        logic [1:0] alusrc_b;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       ext_zero;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_imm_alu(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode/funct -> ALUop decode, steered by the current state class.
module alu_op_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  alu_class_t  alu_class,
    output logic [3:0]  alu_op,
    output logic        ext_zero,
    output logic        funct_valid
);

    logic [3:0] r_op;
    logic [3:0] i_op;

    always_comb begin
        funct_valid = 1'b1;
        r_op        = ALU_ADD;
        case (funct)
            FN_ADD, FN_ADDU: r_op = ALU_ADD;
            FN_SUB, FN_SUBU: r_op = ALU_SUB_AB;
            FN_AND:          r_op = ALU_AND;
            FN_OR:           r_op = ALU_OR;
            FN_NOR:          r_op = ALU_NOR;
            FN_SLT:          r_op = ALU_SLT;
            FN_SLL:          r_op = ALU_SLL;
            FN_SRL:          r_op = ALU_SRL;
            default:         funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        i_op = ALU_ADD;
        case (opcode)
            OP_ANDI: i_op = ALU_AND;
            OP_ORI:  i_op = ALU_OR;
            OP_SLTI: i_op = ALU_SLT;
            default: i_op = ALU_ADD;
        endcase
    end

    // Logical immediates zero-extend; everything else sign-extends.
    always_comb begin
        alu_op   = ALU_ADD;
        ext_zero = 1'b0;
        case (alu_class)
            CLS_RTYPE:  alu_op = r_op;
            CLS_IMM: begin
                alu_op   = i_op;
                ext_zero = (opcode == OP_ANDI) || (opcode == OP_ORI);
            end
            CLS_BRANCH: alu_op = ALU_SUB_AB;
            default:    alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-subset control FSM driving datapath muxes, enables and ALUop.
// Define MC_CTRL_BNE_EN to decode opcode 0x05 as bne; otherwise it is illegal.
module mc_control_unit
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] ALUop,
    output logic       alusrc_a,
    output logic [1:0] alusrc_b,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       ir_we,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       ext_zero,
    output logic       instr_done,
    output logic       illegal
);

    state_t     state;
    state_t     state_next;
    alu_class_t alu_class;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic [3:0] dec_aluop;
    logic       dec_ext_zero;
    logic       funct_valid;

    alu_op_decoder u_alu_op_decoder (
        .opcode      (opcode),
        .funct       (funct),
        .alu_class   (alu_class),
        .alu_op      (dec_aluop),
        .ext_zero    (dec_ext_zero),
        .funct_valid (funct_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_comb begin
        alu_class = CLS_ADD;
        case (state)
            S_EXEC_R: alu_class = CLS_RTYPE;
            S_EXEC_I: alu_class = CLS_IMM;
            S_BRANCH: alu_class = CLS_BRANCH;
            default:  alu_class = CLS_ADD;
        endcase
    end

    // Memory handshake: mem_rd/mem_wr is a request held stable from the first
    // cycle of the access until mem_ready is sampled high; that cycle completes
    // the access and the FSM advances on the following edge.
    always_comb begin
        ctrl          = '0;
        state_next    = state;
        ctrl.aluop    = dec_aluop;
        ctrl.ext_zero = dec_ext_zero;
        case (state)
            S_FETCH: begin
                ctrl.mem_rd   = 1'b1;
                ctrl.alusrc_b = SRCB_FOUR;
                ctrl.pc_src   = PCSRC_ALU;
                if (mem_ready) begin
                    ctrl.ir_we = 1'b1;
                    ctrl.pc_we = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl.alusrc_b = SRCB_BRANCH;
                state_next    = S_FETCH;
                if (opcode == OP_RTYPE) begin
                    if (funct_valid) state_next   = S_EXEC_R;
                    else             ctrl.illegal = 1'b1;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_next = S_MEM_ADDR;
                end else if (is_imm_alu(opcode)) begin
                    state_next = S_EXEC_I;
`ifdef MC_CTRL_BNE_EN
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
`else
                end else if (opcode == OP_BEQ) begin
`endif
                    state_next = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_next = S_JUMP;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            S_EXEC_R: begin
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = SRCB_BUSB;
                state_next    = S_R_WB;
            end
            S_EXEC_I: begin
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = SRCB_IMM;
                state_next    = S_I_WB;
            end
            S_R_WB, S_I_WB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.reg_dst    = (state == S_R_WB);
                ctrl.instr_done = 1'b1;
                state_next      = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = SRCB_IMM;
                state_next    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl.mem_rd = 1'b1;
                ctrl.iord   = 1'b1;
                if (mem_ready) state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                state_next      = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_wr = 1'b1;
                ctrl.iord   = 1'b1;
                if (mem_ready) begin
                    ctrl.instr_done = 1'b1;
                    state_next      = S_FETCH;
                end
            end
            S_BRANCH: begin
                ctrl.alusrc_a   = 1'b1;
                ctrl.alusrc_b   = SRCB_BUSB;
                ctrl.pc_src     = PCSRC_ALUOUT;
`ifdef MC_CTRL_BNE_EN
                ctrl.pc_we      = (opcode == OP_BNE) ? !zero : zero;
`else
                ctrl.pc_we      = zero;
`endif
                ctrl.instr_done = 1'b1;
                state_next      = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_we      = 1'b1;
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
                state_next      = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Reset blanks every output so an abandoned instruction has no side effects.
    always_comb begin
        ctrl_out = ctrl;
        if (reset) ctrl_out = '0;
    end

    assign ALUop      = ctrl_out.aluop;
    assign alusrc_a   = ctrl_out.alusrc_a;
    assign alusrc_b   = ctrl_out.alusrc_b;
    assign pc_we      = ctrl_out.pc_we;
    assign pc_src     = ctrl_out.pc_src;
    assign ir_we      = ctrl_out.ir_we;
    assign mem_rd     = ctrl_out.mem_rd;
    assign mem_wr     = ctrl_out.mem_wr;
    assign iord       = ctrl_out.iord;
    assign reg_we     = ctrl_out.reg_we;
    assign reg_dst    = ctrl_out.reg_dst;
    assign mem_to_reg = ctrl_out.mem_to_reg;
    assign ext_zero   = ctrl_out.ext_zero;
    assign instr_done = ctrl_out.instr_done;
    assign illegal    = ctrl_out.illegal;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: per-instruction expected-output scripts feed a
// cycle-by-cycle scoreboard, plus literal checks on latency and decode values.
module tb_mc_control_unit;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc_a;
        logic [1:0] alusrc_b;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       ext_zero;
        logic       instr_done;
        logic       illegal;
    } out_t;

    typedef enum {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_ILL} kind_t;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] ALUop;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       ir_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       ext_zero;
    logic       instr_done;
    logic       illegal;

    out_t dut_o;
    assign dut_o = {ALUop, alusrc_a, alusrc_b, pc_we, pc_src, ir_we, mem_rd, mem_wr,
                    iord, reg_we, reg_dst, mem_to_reg, ext_zero, instr_done, illegal};

    mc_control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ALUop      (ALUop),
        .alusrc_a   (alusrc_a),
        .alusrc_b   (alusrc_b),
        .pc_we      (pc_we),
        .pc_src     (pc_src),
        .ir_we      (ir_we),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .iord       (iord),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .ext_zero   (ext_zero),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    logic [19:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int step  = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (dut_o !== e) begin
                n_bad++;
                $display("FAIL cycle_outputs step %0d op=%h fn=%h got=%h want=%h",
                         step, opcode, funct, dut_o, e);
            end
            step++;
        end
    end

    // Latency and read-window measurement taken from DUT pulses.
    int cyc_cnt  = 0;
    int rd_cnt   = 0;
    int last_len = 0;
    int last_rd  = 0;

    always @(negedge clk) begin
        if (reset) begin
            cyc_cnt = 0;
            rd_cnt  = 0;
        end else begin
            cyc_cnt++;
            if (mem_rd && iord) rd_cnt++;
            if (instr_done || illegal) begin
                last_len = cyc_cnt;
                last_rd  = rd_cnt;
                cyc_cnt  = 0;
                rd_cnt   = 0;
            end
        end
    end

    task automatic pin(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit funct_ok(input logic [5:0] fn);
        return fn inside {6'h00, 6'h02, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h22, 6'h23: return 4'b0001;
            6'h24:        return 4'b0100;
            6'h25:        return 4'b0011;
            6'h27:        return 4'b0110;
            6'h2A:        return 4'b0101;
            6'h00:        return 4'b0111;
            6'h02:        return 4'b1000;
            default:      return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] i_alu(input logic [5:0] op);
        case (op)
            6'h0C:   return 4'b0100;
            6'h0D:   return 4'b0011;
            6'h0A:   return 4'b0101;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic kind_t kind_of(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:                      return funct_ok(fn) ? K_R : K_ILL;
            6'h23:                      return K_LW;
            6'h2B:                      return K_SW;
            6'h08, 6'h0A, 6'h0C, 6'h0D: return K_I;
            6'h04:                      return K_BR;
`ifdef MC_CTRL_BNE_EN
            6'h05:                      return K_BR;
`endif
            6'h02:                      return K_J;
            default:                    return K_ILL;
        endcase
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // ---------------- driver ----------------
    logic [5:0] cur_op = 6'h00;
    logic [5:0] cur_fn = 6'h00;
    logic       dec_illegal;
    logic [3:0] ex_aluop;
    logic       ex_ext;
    logic       ex_pcwe;
    out_t       rst_vec;

    task automatic cycle(input bit rst, input bit mrdy, input bit z, input out_t e);
        @(posedge clk);
        #1;
        reset     = rst;
        mem_ready = mrdy;
        zero      = z;
        opcode    = cur_op;
        funct     = cur_fn;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // zsel < 0 randomizes zero in the branch cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fwait,
                             input int mwait, input bit rst_memwr, input int zsel);
        out_t  e;
        kind_t k;
        bit    z;
        cur_op      = op;
        cur_fn      = fn;
        k           = kind_of(op, fn);
        dec_illegal = 1'b0;

        e = '0;
        e.mem_rd   = 1'b1;
        e.alusrc_b = 2'b01;
        for (int i = 0; i < fwait; i++) cycle(1'b0, 1'b0, rb(), e);
        e.ir_we = 1'b1;
        e.pc_we = 1'b1;
        cycle(1'b0, 1'b1, rb(), e);

        e = '0;
        e.alusrc_b = 2'b11;
        e.illegal  = (k == K_ILL);
        cycle(1'b0, rb(), rb(), e);
        dec_illegal = illegal;

        case (k)
            K_R: begin
                e = '0;
                e.aluop    = r_alu(fn);
                e.alusrc_a = 1'b1;
                cycle(1'b0, rb(), rb(), e);
                ex_aluop = ALUop;
                ex_ext   = ext_zero;
                e = '0;
                e.reg_we     = 1'b1;
                e.reg_dst    = 1'b1;
                e.instr_done = 1'b1;
                cycle(1'b0, rb(), rb(), e);
            end
            K_I: begin
                e = '0;
                e.aluop    = i_alu(op);
                e.alusrc_a = 1'b1;
                e.alusrc_b = 2'b10;
                e.ext_zero = (op == 6'h0C) || (op == 6'h0D);
                cycle(1'b0, rb(), rb(), e);
                ex_aluop = ALUop;
                ex_ext   = ext_zero;
                e = '0;
                e.reg_we     = 1'b1;
                e.instr_done = 1'b1;
                cycle(1'b0, rb(), rb(), e);
            end
            K_LW, K_SW: begin
                e = '0;
                e.alusrc_a = 1'b1;
                e.alusrc_b = 2'b10;
                cycle(1'b0, rb(), rb(), e);
                e = '0;
                e.iord   = 1'b1;
                e.mem_rd = (k == K_LW);
                e.mem_wr = (k == K_SW);
                for (int i = 0; i < mwait; i++) cycle(1'b0, 1'b0, rb(), e);
                if (k == K_SW && rst_memwr) begin
                    cycle(1'b1, rb(), rb(), '0);
                    rst_vec = dut_o;
                end else if (k == K_SW) begin
                    e.instr_done = 1'b1;
                    cycle(1'b0, 1'b1, rb(), e);
                end else begin
                    cycle(1'b0, 1'b1, rb(), e);
                    e = '0;
                    e.reg_we     = 1'b1;
                    e.mem_to_reg = 1'b1;
                    e.instr_done = 1'b1;
                    cycle(1'b0, rb(), rb(), e);
                end
            end
            K_BR: begin
                z = (zsel < 0) ? rb() : zsel[0];
                e = '0;
                e.aluop      = 4'b0001;
                e.alusrc_a   = 1'b1;
                e.pc_src     = 2'b01;
                e.pc_we      = (op == 6'h04) ? z : !z;
                e.instr_done = 1'b1;
                cycle(1'b0, rb(), z, e);
                ex_aluop = ALUop;
                ex_pcwe  = pc_we;
            end
            K_J: begin
                e = '0;
                e.pc_we      = 1'b1;
                e.pc_src     = 2'b10;
                e.instr_done = 1'b1;
                cycle(1'b0, rb(), rb(), e);
            end
            default: ;
        endcase
    endtask

    // ---------------- stimulus ----------------
    logic [5:0] op_pool[11] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05,
                                6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02};
    logic [5:0] fn_pool[10] = '{6'h00, 6'h02, 6'h20, 6'h21, 6'h22, 6'h23,
                                6'h24, 6'h25, 6'h27, 6'h2A};
    logic [5:0] pin_fn[4]   = '{6'h00, 6'h02, 6'h27, 6'h2A};
    logic [3:0] pin_alu[4]  = '{4'b0111, 4'b1000, 4'b0110, 4'b0101};

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h20;

        cycle(1'b1, 1'b1, 1'b0, '0);
        pin("reset_outputs_c0", int'(dut_o), 0);
        cycle(1'b1, 1'b1, 1'b0, '0);
        pin("reset_outputs_c1", int'(dut_o), 0);

        run_instr(6'h00, 6'h20, 0, 0, 1'b0, -1);
        pin("add_latency", last_len, 4);
        pin("add_aluop", int'(ex_aluop), 0);

        for (int i = 0; i < 4; i++) begin
            run_instr(6'h00, pin_fn[i], 0, 0, 1'b0, -1);
            pin("rtype_aluop", int'(ex_aluop), int'(pin_alu[i]));
        end

        run_instr(6'h00, 6'h3F, 0, 0, 1'b0, -1);
        pin("bad_funct_illegal", int'(dec_illegal), 1);
        pin("bad_funct_len", last_len, 2);

        run_instr(6'h23, 6'h00, 0, 3, 1'b0, -1);
        pin("lw_wait_latency", last_len, 8);
        pin("lw_read_window", last_rd, 4);

        run_instr(6'h04, 6'h00, 0, 0, 1'b0, 1);
        pin("beq_taken_pcwe", int'(ex_pcwe), 1);
        pin("beq_aluop", int'(ex_aluop), 1);
        pin("beq_latency", last_len, 3);
        run_instr(6'h04, 6'h00, 0, 0, 1'b0, 0);
        pin("beq_not_taken_pcwe", int'(ex_pcwe), 0);

        run_instr(6'h05, 6'h00, 0, 0, 1'b0, 0);
`ifdef MC_CTRL_BNE_EN
        pin("bne_taken_pcwe", int'(ex_pcwe), 1);
`else
        pin("bne_disabled_illegal", int'(dec_illegal), 1);
`endif

        run_instr(6'h0D, 6'h00, 0, 0, 1'b0, -1);
        pin("ori_aluop", int'(ex_aluop), 3);
        pin("ori_ext_zero", int'(ex_ext), 1);
        run_instr(6'h0A, 6'h00, 0, 0, 1'b0, -1);
        pin("slti_aluop", int'(ex_aluop), 5);
        pin("slti_ext_zero", int'(ex_ext), 0);

        run_instr(6'h02, 6'h00, 0, 0, 1'b0, -1);
        pin("j_latency", last_len, 3);
        run_instr(6'h2B, 6'h00, 0, 0, 1'b0, -1);
        pin("sw_latency", last_len, 4);

        run_instr(6'h2B, 6'h00, 0, 2, 1'b1, -1);
        pin("sw_reset_outputs", int'(rst_vec), 0);
        run_instr(6'h00, 6'h25, 0, 0, 1'b0, -1);

        for (int n = 0; n < 400; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = op_pool[$urandom_range(0, 10)];
            fn = fn_pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 15) == 0) op = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) fn = 6'($urandom_range(0, 63));
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2),
                      ($urandom_range(0, 19) == 0), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle MIPS-subset control unit: the instruction-side driver of the datapath ALU. It sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, decodes opcode/funct into the 4-bit `ALUop` code the ALU consumes, and consumes the ALU `zero` flag to resolve branches. It sits between the instruction register and memory handshake on one side and the datapath mux/enable controls on the other.

## Interface
Parameters: none.

Clocking and reset: one clock; reset is synchronous and active-high.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, combinational, same cycle.
- `mem_ready` in 1: memory access completes this cycle.
- `ALUop` out 4: ALU operation code.
- `alusrc_a` out 1: ALU A source. 0 = PC, 1 = busA.
- `alusrc_b` out 2: ALU B source. 00 = busB, 01 = const 4, 10 = sign/zero-ext imm, 11 = sext imm<<2.
- `pc_we` out 1: PC write enable.
- `pc_src` out 2: PC source. 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `ir_we` out 1: IR write enable.
- `mem_rd` out 1: memory read request.
- `mem_wr` out 1: memory write request.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `reg_we` out 1: register-file write enable.
- `reg_dst` out 1: write-register select. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: write-back source. 0 = ALUOut, 1 = MDR.
- `ext_zero` out 1: immediate extension. 1 = zero-extend (andi/ori), 0 = sign-extend.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.
- `illegal` out 1: one-cycle pulse in DECODE on an unsupported opcode or funct.

## Operation
ALUop encoding:
- 0000 add, 0001 A−B, 0010 B−A, 0011 or, 0100 and, 0101 slt, 0110 nor, 0111 sll, 1000 srl.

R-type funct mapping:
- 0x20/0x21 → add
- 0x22/0x23 → sub
- 0x24 → and
- 0x25 → or
- 0x27 → nor
- 0x2A → slt
- 0x00 → sll
- 0x02 → srl
- Any other funct: illegal.

Opcodes:
- R-type 0x00
- lw 0x23, sw 0x2B
- beq 0x04, bne 0x05
- addi 0x08, andi 0x0C, ori 0x0D, slti 0x0A
- j 0x02
- Any other opcode: illegal.

States and transitions:
- FETCH: `mem_rd`=1, `iord`=0, alusrc_a=0, alusrc_b=01, ALUop add. Holds until `mem_ready`. On the ready cycle: `ir_we`=1, `pc_we`=1, pc_src=00, next DECODE.
- DECODE: alusrc_a=0, alusrc_b=11, ALUop add (branch target into ALUOut).
  - R → EXEC_R
  - lw/sw → MEM_ADDR
  - I-ALU → EXEC_I
  - beq/bne → BRANCH
  - j → JUMP
  - illegal → FETCH with `illegal`=1.
- EXEC_R: alusrc_a=1, alusrc_b=00, ALUop from funct; next R_WB.
- EXEC_I: alusrc_a=1, alusrc_b=10, ALUop = add/and/or/slt; `ext_zero`=1 for andi/ori; next I_WB.
- R_WB / I_WB: `reg_we`=1, mem_to_reg=0, reg_dst=1 (R) or 0 (I), `instr_done`=1; next FETCH.
- MEM_ADDR: alusrc_a=1, alusrc_b=10, ALUop add. lw → MEM_RD, sw → MEM_WR.
- MEM_RD: `mem_rd`=1, `iord`=1; holds until `mem_ready`, then MEM_WB.
- MEM_WB: `reg_we`=1, mem_to_reg=1, reg_dst=0, `instr_done`=1; next FETCH.
- MEM_WR: `mem_wr`=1, `iord`=1; holds until `mem_ready`. On the ready cycle `instr_done`=1, then FETCH.
- BRANCH: alusrc_a=1, alusrc_b=00, ALUop sub, pc_src=01.
  - `pc_we` = `zero` (beq) or `!zero` (bne).
  - `instr_done`=1; next FETCH.
- JUMP: `pc_we`=1, pc_src=10, `instr_done`=1; next FETCH.

Output defaults: every output not listed for a state is 0.

## Timing
- Reset: state ← FETCH on the clock edge with `reset`=1. While `reset`=1, all outputs are forced to 0, including `mem_rd`.
- Reset mid-instruction: the instruction is abandoned, with no `reg_we`, `mem_wr` or `pc_we`.
- State/output style:
  - Moore outputs decode the state register.
  - `pc_we` in BRANCH is combinational on `zero`.
  - `ir_we` and `pc_we` in FETCH, and `instr_done` in MEM_WR, are combinational on `mem_ready`.
- Latency with `mem_ready` tied high:
  - j, beq, bne: 3 cycles.
  - R-type, I-ALU, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- `mem_rd` / `mem_wr` stay asserted and stable until `mem_ready` is sampled high.
- `illegal` and `instr_done` are never high together.

## Configuration
- `MC_CTRL_BNE_EN` defined: opcode 0x05 decodes as bne, as specified above.
- `MC_CTRL_BNE_EN` undefined: opcode 0x05 is illegal. DECODE pulses `illegal` and returns to FETCH, with no PC update beyond PC+4.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - ALUop localparams (ALU_ADD … ALU_SRL);
  - opcode and funct localparams;
  - alusrc_b and pc_src encodings.
- Sub-module `alu_op_decoder`: combinational (opcode, funct, state class) → ALUop, `ext_zero`, funct-valid. It is instantiated once inside `mc_control_unit`.

## Test plan
- Reset held 2 cycles, then released with `mem_ready`=1, opcode=0x00, funct=0x20:
  - All outputs are 0 during reset.
  - Then FETCH, DECODE, EXEC_R (ALUop=0000, alusrc_a=1, alusrc_b=00), R_WB (`reg_we`=1, reg_dst=1, `instr_done`=1).
- lw (0x23) with `mem_ready` low for 3 cycles in MEM_RD:
  - `mem_rd`=1 and `iord`=1 held for 4 cycles.
  - Then MEM_WB: `reg_we`=1, mem_to_reg=1. Total 8 cycles.
- beq (0x04):
  - `zero`=1 in BRANCH → `pc_we`=1, pc_src=01, ALUop=0001.
  - `zero`=0 → `pc_we`=0.
  - bne (0x05) with `zero`=0 → `pc_we`=1; with the macro undefined → `illegal`=1 in DECODE.
- Every supported funct under opcode 0x00: check the ALUop mapping. 0x00 → 0111, 0x02 → 1000, 0x27 → 0110, 0x2A → 0101. funct 0x3F → `illegal` pulse and FETCH next cycle.
- ori (0x0D) → EXEC_I with ALUop=0011 and `ext_zero`=1. slti (0x0A) → ALUop=0101 and `ext_zero`=0.
- sw (0x2B) with `reset` asserted during MEM_WR: `mem_wr` drops in the reset cycle, and FETCH follows after release.
